// File: rtl/soma_acumulador_nbits_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | soma_acumulador_nbits_pkg                                          |
// | Shared operation encoding and default width for the accumulator.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package soma_acumulador_nbits_pkg;

  localparam int DEFAULT_NBITS = 8;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

endpackage
`default_nettype wire

// File: rtl/soma_acumulador_nbits_flags.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | flags_nbits                                                        |
// | Zero / negative / even flags of the accumulator value.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module flags_nbits #(
  parameter int NBITS = 8
) (
  input  logic [NBITS-1:0] S,
  output logic             Z,
  output logic             N,
  output logic             P
);

  assign Z = (S == '0);
  assign N = S[NBITS-1];
  assign P = ~S[0];

endmodule
`default_nettype wire

// File: rtl/soma_acumulador_nbits.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | soma_acumulador_nbits                                              |
// | Signed accumulator (ADD/SUB/LOAD/CLEAR) with valid/ready handshake,|
// | optional saturation and carry/overflow flags. Latency 1.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module soma_acumulador_nbits
  import soma_acumulador_nbits_pkg::*;
#(
  parameter int NBITS    = DEFAULT_NBITS,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [NBITS-1:0] A,
  output logic [NBITS-1:0] S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Z,
  output logic             N,
  output logic             P,
  output logic             C,
  output logic             V,
  output logic             OVF_STICKY
);

  localparam logic [NBITS-1:0] c_max = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] c_min = {1'b1, {(NBITS-1){1'b0}}};

  logic [NBITS-1:0] r_acc;
  logic             r_c;
  logic             r_v;
  logic             r_sticky;
  logic             r_out_valid;

  op_t              w_op;
  logic             w_accept;
  logic [NBITS:0]   w_sum;
  logic [NBITS:0]   w_dif;
  logic [NBITS-1:0] w_res;
  logic [NBITS-1:0] w_final;
  logic             w_c;
  logic             w_v;

  assign w_op     = op_t'(op);
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_sum = {1'b0, r_acc} + {1'b0, A};
  assign w_dif = {1'b0, r_acc} - {1'b0, A};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[NBITS-1:0];
        w_c   = w_sum[NBITS];
        w_v   = (r_acc[NBITS-1] == A[NBITS-1]) && (w_sum[NBITS-1] != r_acc[NBITS-1]);
      end
      OP_SUB: begin
        w_res = w_dif[NBITS-1:0];
        w_c   = ~w_dif[NBITS];
        w_v   = (r_acc[NBITS-1] != A[NBITS-1]) && (w_dif[NBITS-1] != r_acc[NBITS-1]);
      end
      OP_LOAD: begin
        w_res = A;
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  // Overflow direction follows the accumulator sign for both ADD and SUB.
  generate
    if (SATURATE) begin : g_sat
      assign w_final = w_v ? (r_acc[NBITS-1] ? c_min : c_max) : w_res;
    end else begin : g_wrap
      assign w_final = w_res;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc       <= '0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_acc       <= w_final;
      r_c         <= w_c;
      r_v         <= w_v;
      r_out_valid <= 1'b1;
      if (w_op == OP_CLEAR) begin
        r_sticky <= 1'b0;
      end else if (w_v) begin
        r_sticky <= 1'b1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  flags_nbits #(
    .NBITS (NBITS)
  ) u_flags (
    .S (r_acc),
    .Z (Z),
    .N (N),
    .P (P)
  );

  assign S          = r_acc;
  assign C          = r_c;
  assign V          = r_v;
  assign OVF_STICKY = r_sticky;
  assign out_valid  = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_soma_acumulador_nbits.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_soma_acumulador_nbits                                           |
// | Directed bench: wrap/saturate variants at 8 and 16 bits.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_soma_acumulador_nbits;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  op;
  logic [7:0]  a8;
  logic [15:0] a16;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // instance outputs: w8 (8b wrap), s8 (8b sat), w16 (16b wrap), s16 (16b sat)
  logic        w8_ir, w8_ov, w8_z, w8_n, w8_p, w8_c, w8_v, w8_st;
  logic [7:0]  w8_s;
  logic        s8_ir, s8_ov, s8_z, s8_n, s8_p, s8_c, s8_v, s8_st;
  logic [7:0]  s8_s;
  logic        w16_ir, w16_ov, w16_z, w16_n, w16_p, w16_c, w16_v, w16_st;
  logic [15:0] w16_s;
  logic        s16_ir, s16_ov, s16_z, s16_n, s16_p, s16_c, s16_v, s16_st;
  logic [15:0] s16_s;

  always #5 clock = ~clock;

  soma_acumulador_nbits #(.NBITS(8), .SATURATE(1'b0)) u_w8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(w8_ir), .op(op), .A(a8),
    .S(w8_s), .out_valid(w8_ov), .out_ready(out_ready), .Z(w8_z), .N(w8_n), .P(w8_p),
    .C(w8_c), .V(w8_v), .OVF_STICKY(w8_st));

  soma_acumulador_nbits #(.NBITS(8), .SATURATE(1'b1)) u_s8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s8_ir), .op(op), .A(a8),
    .S(s8_s), .out_valid(s8_ov), .out_ready(out_ready), .Z(s8_z), .N(s8_n), .P(s8_p),
    .C(s8_c), .V(s8_v), .OVF_STICKY(s8_st));

  soma_acumulador_nbits #(.NBITS(16), .SATURATE(1'b0)) u_w16 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(w16_ir), .op(op), .A(a16),
    .S(w16_s), .out_valid(w16_ov), .out_ready(out_ready), .Z(w16_z), .N(w16_n), .P(w16_p),
    .C(w16_c), .V(w16_v), .OVF_STICKY(w16_st));

  soma_acumulador_nbits #(.NBITS(16), .SATURATE(1'b1)) u_s16 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s16_ir), .op(op), .A(a16),
    .S(s16_s), .out_valid(s16_ov), .out_ready(out_ready), .Z(s16_z), .N(s16_n), .P(s16_p),
    .C(s16_c), .V(s16_v), .OVF_STICKY(s16_st));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [7:0] a);
    op  = o;
    a8  = a;
    a16 = {{8{a[7]}}, a};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'b00, 8'd0);
    tick();
    tick();
    chk("rst_s",   w8_s,  0);
    chk("rst_ov",  w8_ov, 0);
    chk("rst_z",   w8_z,  1);
    chk("rst_n",   w8_n,  0);
    chk("rst_p",   w8_p,  1);
    chk("rst_c",   w8_c,  0);
    chk("rst_v",   w8_v,  0);
    chk("rst_st",  w8_st, 0);
    chk("rst_ir",  w8_ir, 1);
    reset = 1'b0;

    // LOAD 5, ADD 3
    in_valid = 1'b1; drive(2'b10, 8'd5);
    tick();
    chk("load5_s",  w8_s,  8'd5);
    chk("load5_ov", w8_ov, 1);
    drive(2'b00, 8'd3);
    tick();
    chk("add3_s",  w8_s,  8'd8);
    chk("add3_z",  w8_z,  0);
    chk("add3_n",  w8_n,  0);
    chk("add3_p",  w8_p,  1);
    chk("add3_ov", w8_ov, 1);
    in_valid = 1'b0;
    tick();
    chk("drain_ov", w8_ov, 0);
    chk("drain_s",  w8_s,  8'd8);

    // LOAD 127, ADD 1: positive overflow
    in_valid = 1'b1; drive(2'b10, 8'd127);
    tick();
    drive(2'b00, 8'd1);
    tick();
    chk("ovf_w8_s",   w8_s,  8'h80);
    chk("ovf_w8_v",   w8_v,  1);
    chk("ovf_w8_n",   w8_n,  1);
    chk("ovf_w8_c",   w8_c,  0);
    chk("ovf_w8_st",  w8_st, 1);
    chk("ovf_s8_s",   s8_s,  8'h7F);
    chk("ovf_s8_v",   s8_v,  1);
    chk("ovf_s8_st",  s8_st, 1);
    chk("ovf_w16_s",  w16_s, 16'd128);
    chk("ovf_w16_v",  w16_v, 0);

    // LOAD 0, SUB 1: borrow, no overflow
    drive(2'b10, 8'd0);
    tick();
    drive(2'b01, 8'd1);
    tick();
    chk("sub_s",  w8_s,  8'hFF);
    chk("sub_c",  w8_c,  0);
    chk("sub_n",  w8_n,  1);
    chk("sub_p",  w8_p,  0);
    chk("sub_v",  w8_v,  0);
    chk("sub_st", w8_st, 1);
    drive(2'b11, 8'd0);
    tick();
    chk("clr_s",   w8_s,  0);
    chk("clr_z",   w8_z,  1);
    chk("clr_st",  w8_st, 0);
    chk("clr_sst", s8_st, 0);

    // LOAD -1, ADD 1: carry out, result zero
    drive(2'b10, 8'hFF);
    tick();
    drive(2'b00, 8'd1);
    tick();
    chk("cry_s", w8_s, 0);
    chk("cry_c", w8_c, 1);
    chk("cry_v", w8_v, 0);
    chk("cry_z", w8_z, 1);

    // LOAD min, SUB 1: negative overflow at both widths
    op = 2'b10; a8 = 8'h80; a16 = 16'h8000;
    tick();
    op = 2'b01; a8 = 8'd1; a16 = 16'd1;
    tick();
    chk("neg_w8_s",  w8_s,  8'h7F);
    chk("neg_w8_v",  w8_v,  1);
    chk("neg_s8_s",  s8_s,  8'h80);
    chk("neg_w16_s", w16_s, 16'h7FFF);
    chk("neg_w16_v", w16_v, 1);
    chk("neg_w16_c", w16_c, 1);
    chk("neg_s16_s", s16_s, 16'h8000);
    chk("neg_s16_v", s16_v, 1);
    chk("neg_s16_st", s16_st, 1);

    // Backpressure: hold for 3 cycles, then consume+accept together
    drive(2'b10, 8'd10);
    tick();
    chk("bp_load_s", w8_s, 8'd10);
    out_ready = 1'b0; drive(2'b00, 8'd1);
    #1;
    chk("bp_ir0", w8_ir, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_s",  w8_s,  8'd10);
      chk("bp_hold_ov", w8_ov, 1);
      chk("bp_hold_ir", w8_ir, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ir1", w8_ir, 1);
    tick();
    chk("bp_acc_s",  w8_s,  8'd11);
    chk("bp_acc_ov", w8_ov, 1);

    // Reset overrides a pending result and a simultaneous offer
    out_ready = 1'b0; in_valid = 1'b1; drive(2'b00, 8'd4); reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("rov_s",  w8_s,  0);
    chk("rov_ov", w8_ov, 0);
    chk("rov_z",  w8_z,  1);
    chk("rov_p",  w8_p,  1);
    chk("rov_ir", w8_ir, 1);
    chk("rov_st", s16_st, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
